fetch_stage: RTL and testbench

Instruction fetch stage: owns the program counter and issues word reads to instruction memory over a valid/ready request channel with a fixed-order response channel. Responses are buffered and presented as an instruction/PC pair to the decode stage. The stage honours the decode stage's `stall_flg` hold protocol and flushes on a redirect from execute (branch, jump, trap). While no instruction is available, it presents a NOP bubble.

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_fetch_buffer.sv | 64 ++++++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the instruction fetch stage.
//   INST_NOP      - instruction presented to decode while no real one exists
//   fetch_state_t - request FSM: FETCH_WAIT means one request is outstanding
//   fetch_entry_t - one fetch buffer entry, {pc, inst}
package fetch_stage_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_fetch_buffer.sv
// fetch_buffer: synchronous FIFO of {pc, inst} entries between the memory
// response channel and the decode output register.
//   clk, rst   - clock, synchronous active-high reset
//   push       - write push_data (ignored when full)
//   push_data  - entry to write
//   pop        - advance the head (ignored when empty)
//   flush      - empty the FIFO; wins over push and pop
//   count      - number of valid entries, 0..BUF_DEPTH
//   head       - oldest entry, meaningful only when count != 0
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2,
    localparam int unsigned AW = $clog2(BUF_DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t   mem [BUF_DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        do_push = push && (count != CW'(BUF_DEPTH));
        do_pop  = pop && (count != '0);
    end

    assign head = mem[rd_ptr];

    // Storage is not reset; entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter, issues one word read at a time to
// instruction memory, buffers responses and presents {pc, inst} to decode.
//   clk, rst                 - clock, synchronous active-high reset
//   imem_req_valid/ready     - request handshake; imem_req_addr is 4-aligned
//   imem_resp_valid/data     - in-order read data, one per accepted request
//   redirect_valid/pc        - flush and restart fetch at redirect_pc & ~3
//   stall_flg                - decode holds; output registers frozen
//   output_inst/reg_pc/valid - instruction to decode; NOP when valid is low
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall_flg,
    output logic [31:0] output_inst,
    output logic [31:0] output_reg_pc,
    output logic        output_valid
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          drop;
    logic [CW-1:0] buf_count;
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_in;
    logic          resp_take;
    logic          buf_push;
    logic          buf_pop;

    // Issuing only while a slot is free reserves room for the response.
    always_comb begin
        imem_req_valid = (state == FETCH_IDLE) && (buf_count < CW'(BUF_DEPTH))
                         && !redirect_valid && !rst;
        resp_take      = (state == FETCH_WAIT) && imem_resp_valid;
        buf_push       = resp_take && !drop && !redirect_valid;
        buf_pop        = !stall_flg && !redirect_valid && (buf_count != '0);
        buf_in.pc      = req_pc;
        buf_in.inst    = imem_resp_data;
    end

    assign imem_req_addr = fetch_pc;

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .count     (buf_count),
        .head      (buf_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH_IDLE;
            fetch_pc      <= RESET_PC;
            req_pc        <= '0;
            drop          <= 1'b0;
            output_inst   <= INST_NOP;
            output_reg_pc <= '0;
            output_valid  <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc     <= redirect_pc & ~32'h3;
            output_inst  <= INST_NOP;
            output_valid <= 1'b0;
            // An in-flight request with no response yet will still answer;
            // wait for it and throw it away before issuing the new target.
            if ((state == FETCH_WAIT) && !imem_resp_valid) begin
                drop  <= 1'b1;
                state <= FETCH_WAIT;
            end else begin
                drop  <= 1'b0;
                state <= FETCH_IDLE;
            end
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
                state    <= FETCH_WAIT;
            end
            if (resp_take) begin
                drop  <= 1'b0;
                state <= FETCH_IDLE;
            end
            if (!stall_flg) begin
                if (buf_count != '0) begin
                    output_inst   <= buf_head.inst;
                    output_reg_pc <= buf_head.pc;
                    output_valid  <= 1'b1;
                end else begin
                    output_inst  <= INST_NOP;
                    output_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] XMASK  = 32'hFFFF_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_flg;
    logic [31:0] output_inst;
    logic [31:0] output_reg_pc;
    logic        output_valid;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall_flg       (stall_flg),
        .output_inst     (output_inst),
        .output_reg_pc   (output_reg_pc),
        .output_valid    (output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [31:0] exp_addr;
    int          resp_delay;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    bit          last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, advance past posedge, then play the
    // memory model and check the output register against the scoreboard.
    task automatic tick();
        logic        pre_acc, pre_rst, pre_flush, pre_stall;
        logic [31:0] a, rp, s_inst, s_pc;
        logic        s_valid;
        logic [63:0] e;
        @(negedge clk);
        pre_acc   = imem_req_valid && imem_req_ready;
        a         = imem_req_addr;
        rp        = redirect_pc;
        pre_rst   = rst;
        pre_flush = rst || redirect_valid;
        pre_stall = stall_flg;
        s_inst    = output_inst;
        s_pc      = output_reg_pc;
        s_valid   = output_valid;
        @(posedge clk);
        #1;
        last_acc = pre_acc;
        if (pre_flush) begin
            sb.delete();
            exp_addr = pre_rst ? RST_PC : (rp & ~32'h3);
        end
        if (pre_acc) begin
            chk("req_addr", a, exp_addr);
            exp_addr = exp_addr + 32'd4;
            sb.push_back({a, a ^ XMASK});
            pend      = 1'b1;
            pend_addr = a;
            pend_cnt  = resp_delay - 1;
        end
        imem_resp_valid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = pend_addr ^ XMASK;
                pend            = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (pre_flush) begin
            chk("flush_valid", {31'b0, output_valid}, 32'd0);
            chk("flush_inst", output_inst, NOP);
            if (pre_rst) chk("rst_pc", output_reg_pc, 32'd0);
        end else if (pre_stall) begin
            chk("hold_inst", output_inst, s_inst);
            chk("hold_pc", output_reg_pc, s_pc);
            chk("hold_valid", {31'b0, output_valid}, {31'b0, s_valid});
        end else if (output_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=pc_%h expected=no_instruction", output_reg_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_pc", output_reg_pc, e[63:32]);
                chk("out_inst", output_inst, e[31:0]);
            end
        end else begin
            chk("bubble_inst", output_inst, NOP);
        end
    endtask

    task automatic wait_acc(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 20);
        checks++;
        assert (last_acc) else begin
            errors++;
            $error("FAIL %s observed=no_accept expected=accept_within_20", tag);
        end
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        stall_flg       = 1'b0;
        exp_addr        = RST_PC;
        resp_delay      = 1;
        pend            = 1'b0;
        pend_addr       = '0;
        pend_cnt        = 0;
        last_acc        = 1'b0;

        // Reset, then first request and 3-cycle latency.
        repeat (2) tick();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, RST_PC);
        tick();
        chk("first_accept", {31'b0, last_acc}, 32'd1);
        chk("lat_n1_valid", {31'b0, output_valid}, 32'd0);
        tick();
        chk("lat_n2_valid", {31'b0, output_valid}, 32'd0);
        tick();
        chk("lat_n3_valid", {31'b0, output_valid}, 32'd1);
        chk("lat_n3_pc", output_reg_pc, RST_PC);
        chk("lat_n3_inst", output_inst, RST_PC ^ XMASK);
        repeat (12) tick();

        // Memory not ready: address held, pipeline drains to bubbles.
        imem_req_ready = 1'b0;
        repeat (8) begin
            tick();
            chk("noready_addr", imem_req_addr, exp_addr);
        end
        chk("noready_valid", {31'b0, output_valid}, 32'd0);
        chk("noready_inst", output_inst, NOP);
        chk("noready_req", {31'b0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b1;

        // Decode stall: outputs frozen, buffer fills, then drains in order.
        stall_flg = 1'b1;
        repeat (6) tick();
        chk("full_no_req", {31'b0, imem_req_valid}, 32'd0);
        stall_flg = 1'b0;
        repeat (10) tick();

        // Redirect while waiting; stale response arrives a cycle later.
        resp_delay = 2;
        wait_acc("redir_wait_acc");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        resp_delay     = 1;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("redir_req_addr", imem_req_addr, 32'h0000_0200);
        chk("redir_bubble", {31'b0, output_valid}, 32'd0);
        repeat (8) tick();

        // Redirect in the same cycle as a response.
        resp_delay = 1;
        wait_acc("same_cycle_acc");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("same_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("same_req_addr", imem_req_addr, 32'h0000_0300);
        repeat (8) tick();

        // Reset with a request outstanding; its response lands after reset.
        resp_delay = 2;
        wait_acc("rst_mid_acc");
        rst = 1'b1;
        tick();
        resp_delay = 1;
        rst = 1'b0;
        #1;
        chk("rstmid_inst", output_inst, NOP);
        chk("rstmid_pc", output_reg_pc, 32'd0);
        chk("rstmid_valid", {31'b0, output_valid}, 32'd0);
        chk("rstmid_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rstmid_req_addr", imem_req_addr, RST_PC);
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
